// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter.
package mem_arb_pkg;

    localparam int unsigned NmDefault    = 2;
    localparam int unsigned AddrWDefault = 16;
    localparam int unsigned DataWDefault = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after ptr_i, upward with wrap.
module rr_pick #(
    parameter int unsigned NM    = 2,
    parameter int unsigned IDX_W = $clog2(NM)
) (
    input  logic [NM-1:0]    req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Scan NM candidates starting at ptr+1; the first hit wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= NM; k++) begin
            sum = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NM)) begin
                sum = sum - (IDX_W + 1)'(NM);
            end
            cand = IDX_W'(sum);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory between NM masters.
// One transaction in flight: IDLE (sample/grant) -> ISSUE (drive memory) -> RESP (ack).
// Optional per-master grant counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NM     = NmDefault,
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NM-1:0]        m_req,
    input  logic [NM-1:0]        m_W,
    input  logic [NM*32-1:0]     m_addr,
    input  logic [NM*DATA_W-1:0] m_wdata,
    output logic [DATA_W-1:0]    m_rdata,
    output logic [NM-1:0]        m_ack,
    output logic [ADDR_W-1:0]    realaddr,
    output logic [DATA_W-1:0]    dout,
    output logic                 W,
`ifdef MEM_ARB_STATS_EN
    input  logic [$clog2(NM)-1:0] stat_sel,
    output logic [31:0]           stat_count,
`endif
    input  logic [DATA_W-1:0]    din
);

    localparam int unsigned IDX_W = $clog2(NM);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              w_q, w_d;
    logic [NM-1:0]     ack_q, ack_d;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;

    rr_pick #(
        .NM    (NM),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (m_req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Next-state logic; memory-side outputs are loaded on grant so they are
    // already registered when the FSM sits in ISSUE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        w_d     = 1'b0;
        ack_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StIssue;
                    idx_d   = pick_idx;
                    addr_d  = m_addr[32*pick_idx +: ADDR_W];
                    wdata_d = m_wdata[DATA_W*pick_idx +: DATA_W];
                    w_d     = m_W[pick_idx];
                end
            end
            StIssue: begin
                state_d      = StResp;
                addr_d       = '0;
                wdata_d      = '0;
                ack_d[idx_q] = 1'b1;
            end
            StResp: begin
                state_d = StIdle;
                ptr_d   = idx_q;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= IDX_W'(NM - 1);
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            w_q     <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            w_q     <= w_d;
            ack_q   <= ack_d;
        end
    end

    assign realaddr = addr_q;
    assign dout     = wdata_q;
    assign W        = w_q;
    assign m_ack    = ack_q;

    // Memory read data arrives during RESP, the same cycle the ack is high,
    // so it is forwarded there and held at zero otherwise.
    always_comb begin
        m_rdata = '0;
        if (state_q == StResp) begin
            m_rdata = din;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] cnt_q [NM];
    logic [31:0] cnt_d [NM];

    // Saturating grant counters, one per master, stepped on each ack pulse.
    always_comb begin
        for (int unsigned i = 0; i < NM; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ack_q[i] && (cnt_q[i] != 32'hFFFF_FFFF)) begin
                cnt_d[i] = cnt_q[i] + 32'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NM; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NM; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Readback mux; out-of-range selects read zero.
    always_comb begin
        stat_count = '0;
        if ({1'b0, stat_sel} < (IDX_W + 1)'(NM)) begin
            stat_count = cnt_q[stat_sel];
        end
    end
`endif

endmodule
